// File: rtl/satd_pkg.sv
// Shared SATD datapath definitions: sample/residual widths, lane slicing and
// the saturating clip used by reconstruction and any later saturating stage.
package satd_pkg;

  localparam int unsigned LENGTH_DEF = 11;
  localparam int unsigned SAMPLE_W   = LENGTH_DEF + 1;
  localparam int unsigned RESID_W    = LENGTH_DEF + 2;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  // Clamp a signed value into the unsigned range [0, 2^w - 1].
  function automatic logic [31:0] clip_u(input logic signed [31:0] s, input int unsigned w);
    logic signed [31:0] maxv;
    maxv = (32'sd1 <<< w) - 32'sd1;
    if (s < 0)
      return '0;
    else if (s > maxv)
      return maxv;
    else
      return s;
  endfunction

  function automatic logic clip_hit(input logic signed [31:0] s, input int unsigned w);
    logic signed [31:0] maxv;
    maxv = (32'sd1 <<< w) - 32'sd1;
    return (s < 0) || (s > maxv);
  endfunction

endpackage

// File: rtl/recon_lane.sv
// One reconstruction lane: sign-extended PRED+RESID adder and the clip of a
// registered sum. Purely combinational; the top owns the pipeline registers.
module recon_lane
  import satd_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF
) (
  input  logic [LENGTH:0]   pred_i,
  input  logic [LENGTH+1:0] resid_i,
  output logic [LENGTH+2:0] sum_o,
  input  logic [LENGTH+2:0] sum_i,
  output logic [LENGTH:0]   recon_o,
  output logic              sat_o
);

  localparam int unsigned SUM_W = LENGTH + 3;

  logic signed [31:0] sum_ext;

  // Adder feeds stage 1; clip consumes the stage-1 register, so the two
  // halves of this lane sit on opposite sides of that register.
  always_comb begin
    sum_o   = {2'b00, pred_i} + {resid_i[LENGTH+1], resid_i};
    sum_ext = {{(32 - SUM_W){sum_i[SUM_W-1]}}, sum_i};
    recon_o = (LENGTH + 1)'(clip_u(sum_ext, LENGTH + 1));
    sat_o   = clip_hit(sum_ext, LENGTH + 1);
  end

endmodule

// File: rtl/residual_reconstruct.sv
// Two-stage row reconstruction RECON = clip(PRED + RESID) with a stall-
// propagating valid/ready pipe and a per-block row tag.
module residual_reconstruct
  import satd_pkg::*;
#(
  parameter int unsigned LENGTH = LENGTH_DEF,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(LENGTH+1)*WIDTH-1:0]   PRED,
  input  logic [(LENGTH+2)*WIDTH-1:0]   RESID,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(LENGTH+1)*WIDTH-1:0]   RECON,
  output logic [WIDTH-1:0]              out_sat,
  output logic [$clog2(HEIGHT)-1:0]     out_row,
  output logic                          out_last,
  output logic                          block_done
);

  localparam int unsigned SW    = LENGTH + 1;
  localparam int unsigned RW    = LENGTH + 2;
  localparam int unsigned SUMW  = LENGTH + 3;
  localparam int unsigned ROW_W = $clog2(HEIGHT);

  logic [ROW_W-1:0]             row_cnt_q;
  logic                         s1_valid_q;
  logic [WIDTH-1:0][SUMW-1:0]   s1_sum_q, sum_d;
  logic [ROW_W-1:0]             s1_row_q;
  logic                         out_valid_q;
  logic [WIDTH*SW-1:0]          recon_q, recon_d;
  logic [WIDTH-1:0]             sat_q, sat_d;
  logic [ROW_W-1:0]             row_q;
  logic                         last_q;
  logic                         s1_adv, s2_adv, accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    recon_lane #(.LENGTH(LENGTH)) u_lane (
      .pred_i  (PRED[lane_lsb(i, SW) +: SW]),
      .resid_i (RESID[lane_lsb(i, RW) +: RW]),
      .sum_o   (sum_d[i]),
      .sum_i   (s1_sum_q[i]),
      .recon_o (recon_d[lane_lsb(i, SW) +: SW]),
      .sat_o   (sat_d[i])
    );
  end

  always_comb begin
    s2_adv     = !out_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv;
    accept     = in_valid && s1_adv;
    out_valid  = out_valid_q;
    RECON      = recon_q;
    out_sat    = sat_q;
    out_row    = row_q;
    out_last   = last_q;
    block_done = out_valid_q && out_ready && last_q;
  end

  // Counter wraps HEIGHT-1 -> 0 naturally since HEIGHT is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_row_q    <= '0;
      out_valid_q <= 1'b0;
      recon_q     <= '0;
      sat_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      if (accept)
        row_cnt_q <= row_cnt_q + 1'b1;
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sum_q <= sum_d;
          s1_row_q <= row_cnt_q;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          recon_q <= recon_d;
          sat_q   <= sat_d;
          row_q   <= s1_row_q;
          last_q  <= (s1_row_q == ROW_W'(HEIGHT - 1));
        end
      end
    end
  end

endmodule
